// File: rtl/map_table_pkg.sv
// Shared types and sizes for the speculative rename map table.
// Everything that touches the map imports this package.
package map_table_pkg;

  localparam int ARCH_REG_SZ   = 32;
  localparam int PHYS_REG_SZ   = 64;
  localparam int N             = 3;
  localparam int ARCH_IDX_BITS = $clog2(ARCH_REG_SZ);
  localparam int PHYS_REG_BITS = $clog2(PHYS_REG_SZ);

  typedef logic [ARCH_IDX_BITS-1:0] arch_idx_t;
  typedef logic [PHYS_REG_BITS-1:0] phys_tag_t;

  localparam arch_idx_t ZERO_REG = '0;

  typedef struct packed {
    phys_tag_t tag;
    logic      ready;
  } map_entry_t;

  typedef struct packed {
    logic      valid;
    arch_idx_t src1_idx;
    arch_idx_t src2_idx;
    arch_idx_t dest_idx;
    phys_tag_t new_tag;
  } rename_slot_t;

  // True when any valid CDB lane is broadcasting the given tag.
  function automatic logic cdb_hit(input phys_tag_t tag,
                                   input logic [N-1:0] cdb_valid,
                                   input logic [N-1:0][PHYS_REG_BITS-1:0] cdb_tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (cdb_valid[k] && (cdb_tag[k] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/map_table_if.sv
// Dispatch-side bundle for the rename map: rename slots, CDB, recovery and results.
// Dispatch drives through the master modport; the map table sits on the slave side.
interface map_table_if;
  import map_table_pkg::*;

  logic [N-1:0]                     rename_valid;
  logic [N-1:0][ARCH_IDX_BITS-1:0]  src1_idx;
  logic [N-1:0][ARCH_IDX_BITS-1:0]  src2_idx;
  logic [N-1:0][ARCH_IDX_BITS-1:0]  dest_idx;
  logic [N-1:0][PHYS_REG_BITS-1:0]  new_tag;
  logic [N-1:0]                     cdb_valid;
  logic [N-1:0][PHYS_REG_BITS-1:0]  cdb_tag;
  logic                             mispredict;
  logic [ARCH_REG_SZ-1:0][PHYS_REG_BITS-1:0] arch_map_in;
  logic [N-1:0][PHYS_REG_BITS-1:0]  src1_tag;
  logic [N-1:0][PHYS_REG_BITS-1:0]  src2_tag;
  logic [N-1:0]                     src1_ready;
  logic [N-1:0]                     src2_ready;
  logic [N-1:0][PHYS_REG_BITS-1:0]  old_tag;

  modport master (
    output rename_valid, src1_idx, src2_idx, dest_idx, new_tag,
    output cdb_valid, cdb_tag, mispredict, arch_map_in,
    input  src1_tag, src2_tag, src1_ready, src2_ready, old_tag
  );

  modport slave (
    input  rename_valid, src1_idx, src2_idx, dest_idx, new_tag,
    input  cdb_valid, cdb_tag, mispredict, arch_map_in,
    output src1_tag, src2_tag, src1_ready, src2_ready, old_tag
  );

endinterface

// File: rtl/map_table_fwd.sv
// Intra-group forwarding: for each slot, finds the youngest earlier valid slot
// whose destination matches this slot's sources or destination.
module map_table_fwd
  import map_table_pkg::*;
(
  input  rename_slot_t [N-1:0] slots,
  output logic [N-1:0]         src1_hit,
  output logic [N-1:0]         src2_hit,
  output logic [N-1:0]         dest_hit,
  output phys_tag_t [N-1:0]    src1_fwd_tag,
  output phys_tag_t [N-1:0]    src2_fwd_tag,
  output phys_tag_t [N-1:0]    dest_fwd_tag
);

  // Scanning older slots in ascending order lets the youngest match overwrite earlier ones.
  always_comb begin
    src1_hit     = '0;
    src2_hit     = '0;
    dest_hit     = '0;
    src1_fwd_tag = '0;
    src2_fwd_tag = '0;
    dest_fwd_tag = '0;
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        if ((i < j) && slots[i].valid && (slots[i].dest_idx != ZERO_REG)) begin
          if (slots[i].dest_idx == slots[j].src1_idx) begin
            src1_hit[j]     = 1'b1;
            src1_fwd_tag[j] = slots[i].new_tag;
          end
          if (slots[i].dest_idx == slots[j].src2_idx) begin
            src2_hit[j]     = 1'b1;
            src2_fwd_tag[j] = slots[i].new_tag;
          end
          if (slots[i].dest_idx == slots[j].dest_idx) begin
            dest_hit[j]     = 1'b1;
            dest_fwd_tag[j] = slots[i].new_tag;
          end
        end
      end
    end
  end

endmodule

// File: rtl/map_table.sv
// Speculative rename map: per-architectural-register {tag, ready} state with
// CDB bypass/update, intra-group forwarding and wholesale mispredict recovery.
module map_table
  import map_table_pkg::*;
(
  input logic          clock,
  input logic          reset,
  map_table_if.slave   rn
);

  map_entry_t              map_q [ARCH_REG_SZ];
  map_entry_t              map_d [ARCH_REG_SZ];
  logic [ARCH_REG_SZ-1:0]  written;

  rename_slot_t [N-1:0]    slots;
  logic [N-1:0]            src1_hit;
  logic [N-1:0]            src2_hit;
  logic [N-1:0]            dest_hit;
  phys_tag_t [N-1:0]       src1_fwd_tag;
  phys_tag_t [N-1:0]       src2_fwd_tag;
  phys_tag_t [N-1:0]       dest_fwd_tag;

  always_comb begin
    slots = '0;
    for (int j = 0; j < N; j++) begin
      slots[j].valid    = rn.rename_valid[j];
      slots[j].src1_idx = rn.src1_idx[j];
      slots[j].src2_idx = rn.src2_idx[j];
      slots[j].dest_idx = rn.dest_idx[j];
      slots[j].new_tag  = rn.new_tag[j];
    end
  end

  map_table_fwd u_fwd (
    .slots        (slots),
    .src1_hit     (src1_hit),
    .src2_hit     (src2_hit),
    .dest_hit     (dest_hit),
    .src1_fwd_tag (src1_fwd_tag),
    .src2_fwd_tag (src2_fwd_tag),
    .dest_fwd_tag (dest_fwd_tag)
  );

  // Forwarded sources are always not-ready: the producer is in this very group.
  always_comb begin
    rn.src1_tag   = '0;
    rn.src1_ready = '0;
    rn.src2_tag   = '0;
    rn.src2_ready = '0;
    rn.old_tag    = '0;
    for (int j = 0; j < N; j++) begin
      if (rn.src1_idx[j] == ZERO_REG) begin
        rn.src1_ready[j] = 1'b1;
      end else if (src1_hit[j]) begin
        rn.src1_tag[j]   = src1_fwd_tag[j];
      end else begin
        rn.src1_tag[j]   = map_q[rn.src1_idx[j]].tag;
        rn.src1_ready[j] = map_q[rn.src1_idx[j]].ready |
                           cdb_hit(map_q[rn.src1_idx[j]].tag, rn.cdb_valid, rn.cdb_tag);
      end

      if (rn.src2_idx[j] == ZERO_REG) begin
        rn.src2_ready[j] = 1'b1;
      end else if (src2_hit[j]) begin
        rn.src2_tag[j]   = src2_fwd_tag[j];
      end else begin
        rn.src2_tag[j]   = map_q[rn.src2_idx[j]].tag;
        rn.src2_ready[j] = map_q[rn.src2_idx[j]].ready |
                           cdb_hit(map_q[rn.src2_idx[j]].tag, rn.cdb_valid, rn.cdb_tag);
      end

      if (rn.dest_idx[j] == ZERO_REG) begin
        rn.old_tag[j] = '0;
      end else if (dest_hit[j]) begin
        rn.old_tag[j] = dest_fwd_tag[j];
      end else begin
        rn.old_tag[j] = map_q[rn.dest_idx[j]].tag;
      end
    end
  end

  // A freshly renamed entry must not pick up a CDB hit meant for the tag it displaced.
  always_comb begin
    map_d   = map_q;
    written = '0;
    for (int i = 0; i < N; i++) begin
      if (rn.rename_valid[i] && (rn.dest_idx[i] != ZERO_REG)) begin
        map_d[rn.dest_idx[i]].tag   = rn.new_tag[i];
        map_d[rn.dest_idx[i]].ready = 1'b0;
        written[rn.dest_idx[i]]     = 1'b1;
      end
    end
    for (int e = 0; e < ARCH_REG_SZ; e++) begin
      if (!written[e] && cdb_hit(map_q[e].tag, rn.cdb_valid, rn.cdb_tag)) begin
        map_d[e].ready = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int e = 0; e < ARCH_REG_SZ; e++) begin
        map_q[e].tag   <= phys_tag_t'(e);
        map_q[e].ready <= 1'b1;
      end
    end else if (rn.mispredict) begin
      for (int e = 0; e < ARCH_REG_SZ; e++) begin
        map_q[e].tag   <= rn.arch_map_in[e];
        map_q[e].ready <= 1'b1;
      end
    end else begin
      map_q <= map_d;
    end
  end

endmodule

// File: tb/tb_map_table.sv
// Directed bench for map_table: hand-computed rename, forwarding, CDB,
// zero-register, recovery and reset scenarios.
module tb_map_table;
  import map_table_pkg::*;

  logic clock = 1'b0;
  logic reset;

  map_table_if rn ();

  map_table dut (
    .clock (clock),
    .reset (reset),
    .rn    (rn)
  );

  always #5 clock = ~clock;

  int assert_count = 0;
  int fail_count   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    rn.rename_valid = '0;
    rn.src1_idx     = '0;
    rn.src2_idx     = '0;
    rn.dest_idx     = '0;
    rn.new_tag      = '0;
    rn.cdb_valid    = '0;
    rn.cdb_tag      = '0;
    rn.mispredict   = 1'b0;
    rn.arch_map_in  = '0;
  endtask

  task automatic applyStimulus(input int slot, input logic v, input int s1, input int s2,
                               input int d, input int nt);
    rn.rename_valid[slot] = v;
    rn.src1_idx[slot]     = arch_idx_t'(s1);
    rn.src2_idx[slot]     = arch_idx_t'(s2);
    rn.dest_idx[slot]     = arch_idx_t'(d);
    rn.new_tag[slot]      = phys_tag_t'(nt);
  endtask

  task automatic setCdb(input int lane, input int tag);
    rn.cdb_valid[lane] = 1'b1;
    rn.cdb_tag[lane]   = phys_tag_t'(tag);
  endtask

  // Inputs change just after the falling edge; checks run 1 time unit later.
  task automatic nextCycle();
    @(negedge clock);
    clearInputs();
  endtask

  initial begin
    reset = 1'b1;
    clearInputs();
    nextCycle();
    reset = 1'b0;

    applyStimulus(0, 1'b0, 5, 0, 7, 0);
    applyStimulus(1, 1'b0, 31, 0, 0, 0);
    #1;
    checkOutput("reset_src1_tag",   32'(rn.src1_tag[0]), 5);
    checkOutput("reset_src1_ready", 32'(rn.src1_ready[0]), 1);
    checkOutput("reset_old_tag",    32'(rn.old_tag[0]), 7);
    checkOutput("reset_src2_zero",  32'(rn.src2_tag[0]), 0);
    checkOutput("reset_r31_tag",    32'(rn.src1_tag[1]), 31);

    nextCycle();
    applyStimulus(0, 1'b1, 1, 2, 3, 40);
    applyStimulus(1, 1'b1, 3, 0, 3, 41);
    applyStimulus(2, 1'b1, 3, 3, 5, 42);
    #1;
    checkOutput("chain_s0_src1",      32'(rn.src1_tag[0]), 1);
    checkOutput("chain_s0_old",       32'(rn.old_tag[0]), 3);
    checkOutput("chain_s1_src1_tag",  32'(rn.src1_tag[1]), 40);
    checkOutput("chain_s1_src1_rdy",  32'(rn.src1_ready[1]), 0);
    checkOutput("chain_s1_old",       32'(rn.old_tag[1]), 40);
    checkOutput("chain_s2_src1_tag",  32'(rn.src1_tag[2]), 41);
    checkOutput("chain_s2_src2_rdy",  32'(rn.src2_ready[2]), 0);
    checkOutput("chain_s2_old",       32'(rn.old_tag[2]), 5);

    nextCycle();
    applyStimulus(0, 1'b0, 3, 5, 3, 0);
    #1;
    checkOutput("chain_tbl3_tag", 32'(rn.src1_tag[0]), 41);
    checkOutput("chain_tbl3_rdy", 32'(rn.src1_ready[0]), 0);
    checkOutput("chain_tbl5_tag", 32'(rn.src2_tag[0]), 42);
    checkOutput("chain_old3",     32'(rn.old_tag[0]), 41);

    nextCycle();
    applyStimulus(0, 1'b1, 0, 0, 4, 45);
    applyStimulus(1, 1'b1, 4, 0, 0, 0);
    setCdb(0, 45);
    #1;
    checkOutput("fwd_ignores_cdb_tag", 32'(rn.src1_tag[1]), 45);
    checkOutput("fwd_ignores_cdb_rdy", 32'(rn.src1_ready[1]), 0);

    nextCycle();
    applyStimulus(0, 1'b0, 4, 0, 0, 0);
    applyStimulus(1, 1'b0, 3, 0, 0, 0);
    #1;
    checkOutput("tbl4_pending_rdy", 32'(rn.src1_ready[0]), 0);

    nextCycle();
    applyStimulus(0, 1'b0, 4, 0, 0, 0);
    applyStimulus(1, 1'b0, 3, 0, 0, 0);
    setCdb(1, 45);
    #1;
    checkOutput("bypass_tag",       32'(rn.src1_tag[0]), 45);
    checkOutput("bypass_rdy",       32'(rn.src1_ready[0]), 1);
    checkOutput("bypass_other_rdy", 32'(rn.src1_ready[1]), 0);

    nextCycle();
    applyStimulus(0, 1'b0, 4, 0, 0, 0);
    #1;
    checkOutput("late_update_rdy", 32'(rn.src1_ready[0]), 1);

    nextCycle();
    applyStimulus(0, 1'b1, 0, 0, 4, 46);
    applyStimulus(1, 1'b0, 0, 0, 6, 50);
    setCdb(0, 45);
    setCdb(2, 41);
    #1;
    checkOutput("stale_old_tag", 32'(rn.old_tag[0]), 45);

    nextCycle();
    applyStimulus(0, 1'b0, 4, 3, 0, 0);
    applyStimulus(1, 1'b0, 6, 0, 0, 0);
    #1;
    checkOutput("stale_tbl4_tag",   32'(rn.src1_tag[0]), 46);
    checkOutput("stale_tbl4_rdy",   32'(rn.src1_ready[0]), 0);
    checkOutput("cdb_tbl3_rdy",     32'(rn.src2_ready[0]), 1);
    checkOutput("invalid_no_write", 32'(rn.src1_tag[1]), 6);

    nextCycle();
    applyStimulus(0, 1'b1, 0, 0, 0, 50);
    applyStimulus(1, 1'b0, 0, 0, 0, 0);
    setCdb(0, 0);
    setCdb(1, 46);
    #1;
    checkOutput("zero_old_tag",   32'(rn.old_tag[0]), 0);
    checkOutput("zero_src_tag",   32'(rn.src1_tag[0]), 0);
    checkOutput("zero_src_rdy",   32'(rn.src1_ready[0]), 1);
    checkOutput("zero_no_fwd",    32'(rn.src1_tag[1]), 0);
    checkOutput("zero_no_fwd_rd", 32'(rn.src1_ready[1]), 1);

    nextCycle();
    applyStimulus(0, 1'b0, 4, 0, 0, 0);
    #1;
    checkOutput("cdb_tbl4_rdy", 32'(rn.src1_ready[0]), 1);

    nextCycle();
    rn.mispredict = 1'b1;
    for (int i = 0; i < ARCH_REG_SZ; i++) rn.arch_map_in[i] = phys_tag_t'(i + 32);
    rn.arch_map_in[3] = phys_tag_t'(12);
    applyStimulus(0, 1'b1, 0, 0, 3, 55);
    applyStimulus(1, 1'b1, 0, 0, 7, 56);
    setCdb(0, 41);

    nextCycle();
    applyStimulus(0, 1'b0, 3, 7, 0, 0);
    applyStimulus(1, 1'b0, 4, 0, 0, 0);
    applyStimulus(2, 1'b0, 5, 0, 3, 0);
    #1;
    checkOutput("mispred_tbl3_tag", 32'(rn.src1_tag[0]), 12);
    checkOutput("mispred_tbl3_rdy", 32'(rn.src1_ready[0]), 1);
    checkOutput("mispred_tbl7_tag", 32'(rn.src2_tag[0]), 39);
    checkOutput("mispred_tbl4_tag", 32'(rn.src1_tag[1]), 36);
    checkOutput("mispred_tbl5_tag", 32'(rn.src1_tag[2]), 37);
    checkOutput("mispred_tbl5_rdy", 32'(rn.src1_ready[2]), 1);
    checkOutput("mispred_old3",     32'(rn.old_tag[2]), 12);

    nextCycle();
    reset         = 1'b1;
    rn.mispredict = 1'b1;
    for (int i = 0; i < ARCH_REG_SZ; i++) rn.arch_map_in[i] = phys_tag_t'(i + 20);
    applyStimulus(0, 1'b1, 0, 0, 3, 60);
    setCdb(0, 12);

    nextCycle();
    reset = 1'b0;
    applyStimulus(0, 1'b0, 3, 7, 0, 0);
    applyStimulus(1, 1'b0, 4, 0, 0, 0);
    #1;
    checkOutput("midreset_tbl3_tag", 32'(rn.src1_tag[0]), 3);
    checkOutput("midreset_tbl3_rdy", 32'(rn.src1_ready[0]), 1);
    checkOutput("midreset_tbl7_tag", 32'(rn.src2_tag[0]), 7);
    checkOutput("midreset_tbl4_tag", 32'(rn.src1_tag[1]), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
